// File: rtl/coeff_pkg.sv
// Shared parameters and state encoding for the 2D FIR coefficient bank controller.
package coeff_pkg;
  localparam int NTAPS   = 25;
  localparam int COEFF_W = 16;
  localparam int ADDR_W  = 11;
  localparam int TAP_W   = $clog2(NTAPS + 1);

  typedef enum logic [1:0] {IDLE, RD, DRAIN, COMMIT} state_t;
endpackage

// File: rtl/coeff_shadow_bank.sv
// Shadow and active coefficient registers; the active bank only changes on commit.
module coeff_shadow_bank
  import coeff_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [TAP_W-1:0]         idx,
  input  logic [COEFF_W-1:0]       data,
  input  logic                     commit,
  output logic [NTAPS*COEFF_W-1:0] coeff_flat
);

  logic [COEFF_W-1:0] shadow [NTAPS];
  logic [COEFF_W-1:0] active [NTAPS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (capture && (idx < TAP_W'(NTAPS))) begin
        shadow[idx] <= data;
      end
      if (commit) begin
        for (int k = 0; k < NTAPS; k++) begin
          active[k] <= shadow[k];
        end
      end
    end
  end

  for (genvar g = 0; g < NTAPS; g++) begin : g_flat
    assign coeff_flat[g*COEFF_W +: COEFF_W] = active[g];
  end

endmodule

// File: rtl/coeff_bank_ctrl.sv
// Arbitrates the coefficient BRAM between host writes and a vsync-triggered
// readout that loads all taps into a shadow bank and commits them between frames.
module coeff_bank_ctrl
  import coeff_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vs_i,
  input  logic [31:0]              wr_addr,
  input  logic                     wr_addr_valid,
  output logic                     wr_addr_ready,
  input  logic [31:0]              wr_data,
  input  logic                     wr_data_valid,
  output logic                     wr_data_ready,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [COEFF_W-1:0]       bram_din,
  input  logic [COEFF_W-1:0]       bram_dout,
  output logic [NTAPS*COEFF_W-1:0] coeff_flat,
  output logic                     coeff_valid,
  output logic                     load_done,
  output logic                     busy,
  output logic                     wr_err,
  output logic                     vs_overrun
);

  state_t           state, next_state;
  logic             vs_dly, vs_edge, pend;
  logic [TAP_W-1:0] idx, cap_idx;
  logic             cap_valid;
  logic             xfer, addr_ok;

  // An edge seen in IDLE takes the port this cycle, so the host is held off immediately.
  assign vs_edge       = vs_i & ~vs_dly;
  assign wr_addr_ready = (state == IDLE) & ~vs_edge;
  assign wr_data_ready = wr_addr_ready;
  assign xfer          = wr_addr_valid & wr_data_valid & wr_addr_ready & wr_data_ready;
  assign addr_ok       = wr_addr < 32'(NTAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (vs_edge || pend) next_state = RD;
      RD:      if (idx == TAP_W'(NTAPS - 1)) next_state = DRAIN;
      DRAIN:   next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (state == RD) begin
      bram_en   = 1'b1;
      bram_addr = ADDR_W'(idx);
    end else if (xfer && addr_ok) begin
      bram_en   = 1'b1;
      bram_we   = 1'b1;
      bram_addr = wr_addr[ADDR_W-1:0];
      bram_din  = wr_data[COEFF_W-1:0];
    end
  end

  // Read data returns one cycle after the read, so the capture index trails idx by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_dly      <= 1'b1;
      pend        <= 1'b0;
      idx         <= '0;
      cap_idx     <= '0;
      cap_valid   <= 1'b0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      coeff_valid <= 1'b0;
      wr_err      <= 1'b0;
      vs_overrun  <= 1'b0;
    end else begin
      vs_dly    <= vs_i;
      busy      <= (next_state != IDLE);
      load_done <= (state == COMMIT);
      cap_valid <= (state == RD);
      cap_idx   <= idx;
      if (state == RD) idx <= idx + TAP_W'(1);
      else             idx <= '0;
      if (state == COMMIT) coeff_valid <= 1'b1;
      if (xfer && !addr_ok) wr_err <= 1'b1;
      if (vs_edge && (state != IDLE)) vs_overrun <= 1'b1;
      if (vs_edge && (state == COMMIT)) pend <= 1'b1;
      else if (state == IDLE)           pend <= 1'b0;
    end
  end

  coeff_shadow_bank u_bank (
    .clk        (clk),
    .rst        (rst),
    .capture    (cap_valid),
    .idx        (cap_idx),
    .data       (bram_dout),
    .commit     (state == COMMIT),
    .coeff_flat (coeff_flat)
  );

endmodule
